dm_responder: RTL and testbench

Synthesizable 256×16 data-memory responder for the 16-bit pipelined processor. It is the memory end of the processor's `dm_addr`/`dm_rd`/`dm_wr` protocol. It adds a host command port so a bench or boot loader can bulk-load memory before `start` and bulk-dump results after `stop`. It replaces behavioural memory models on the processor's data side.

---
 rtl/dm_responder.sv | 182 ++++++++++++++++++
 tb/tb_dm_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// 2^ADDR_WIDTH x DATA_WIDTH data memory: processor port live in IDLE, host LOAD/DUMP command engine otherwise.
// Optional build macro DM_WRITE_FIRST_EN selects write-first bypass for same-cycle processor read+write.
module dm_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [DATA_WIDTH-1:0] dm_w_data,
    output logic [DATA_WIDTH-1:0] dm_r_data,
    input  logic                  cmd_valid,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  cmd_ready,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  dump_valid,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    input  logic                  dump_ready,
    output logic                  cmd_done,
    output logic                  proc_conflict
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP_RD,
        ST_DUMP_OUT
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  dm_r_data_q, dm_r_data_d;
    logic [DATA_WIDTH-1:0]  dump_data_q, dump_data_d;
    logic [ADDR_WIDTH-1:0]  dump_addr_q, dump_addr_d;
    logic                   cmd_done_q, cmd_done_d;
    logic                   proc_conflict_q, proc_conflict_d;

    logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  proc_rd_word;

`ifdef DM_WRITE_FIRST_EN
    // Read and write share dm_addr, so a concurrent write always targets the read address.
    assign proc_rd_word = dm_wr ? dm_w_data : mem[dm_addr];
`else
    assign proc_rd_word = mem[dm_addr];
`endif

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        dm_r_data_d     = dm_r_data_q;
        dump_data_d     = dump_data_q;
        dump_addr_d     = dump_addr_q;
        cmd_done_d      = 1'b0;
        proc_conflict_d = proc_conflict_q;
        mem_we          = 1'b0;
        mem_waddr       = dm_addr;
        mem_wdata       = dm_w_data;

        case (state_q)
            ST_IDLE: begin
                if (dm_wr) begin
                    mem_we = 1'b1;
                end
                if (dm_rd) begin
                    dm_r_data_d = proc_rd_word;
                end
                if (cmd_valid) begin
                    ptr_d = cmd_addr;
                    cnt_d = cmd_len;
                    if (cmd_len == '0) begin
                        cmd_done_d = 1'b1;
                    end else if (cmd_op) begin
                        state_d = ST_DUMP_RD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (dm_rd || dm_wr) begin
                    proc_conflict_d = 1'b1;
                end
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = ld_data;
                    ptr_d     = ptr_q + 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d    = ST_IDLE;
                        cmd_done_d = 1'b1;
                    end
                end
            end

            ST_DUMP_RD: begin
                if (dm_rd || dm_wr) begin
                    proc_conflict_d = 1'b1;
                end
                dump_data_d = mem[ptr_q];
                dump_addr_d = ptr_q;
                state_d     = ST_DUMP_OUT;
            end

            ST_DUMP_OUT: begin
                if (dm_rd || dm_wr) begin
                    proc_conflict_d = 1'b1;
                end
                if (dump_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d    = ST_IDLE;
                        cmd_done_d = 1'b1;
                    end else begin
                        state_d = ST_DUMP_RD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            dm_r_data_q     <= '0;
            dump_data_q     <= '0;
            dump_addr_q     <= '0;
            cmd_done_q      <= 1'b0;
            proc_conflict_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            dm_r_data_q     <= dm_r_data_d;
            dump_data_q     <= dump_data_d;
            dump_addr_q     <= dump_addr_d;
            cmd_done_q      <= cmd_done_d;
            proc_conflict_q <= proc_conflict_d;
        end
    end

    // Storage is deliberately outside the reset domain so loaded words survive an abort.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dm_r_data     = dm_r_data_q;
    assign cmd_ready     = (state_q == ST_IDLE);
    assign ld_ready      = (state_q == ST_LOAD);
    assign dump_valid    = (state_q == ST_DUMP_OUT);
    assign dump_data     = dump_data_q;
    assign dump_addr     = dump_addr_q;
    assign cmd_done      = cmd_done_q;
    assign proc_conflict = proc_conflict_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: host LOAD/DUMP commands, processor port, conflict and reset abort.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dm_addr;
    logic        dm_rd, dm_wr;
    logic [15:0] dm_w_data, dm_r_data;
    logic        cmd_valid, cmd_op;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        cmd_ready;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        dump_valid;
    logic [15:0] dump_data;
    logic [7:0]  dump_addr;
    logic        dump_ready;
    logic        cmd_done;
    logic        proc_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model_mem [0:255];
    logic [15:0] rd_q [$];
    logic [23:0] dump_q [$];

    always #5 clk = ~clk;

    dm_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_w_data(dm_w_data), .dm_r_data(dm_r_data),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_addr(dump_addr),
        .dump_ready(dump_ready), .cmd_done(cmd_done), .proc_conflict(proc_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic proc_write(input logic [7:0] a, input logic [15:0] d);
        dm_addr   = a;
        dm_w_data = d;
        dm_wr     = 1'b1;
        tick();
        dm_wr        = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic proc_read(input logic [7:0] a);
        dm_addr = a;
        dm_rd   = 1'b1;
        rd_q.push_back(model_mem[a]);
        tick();
        dm_rd = 1'b0;
        chk("proc_rd", dm_r_data, rd_q.pop_front());
    endtask

    task automatic send_cmd(input logic op, input logic [7:0] a, input logic [8:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] base, input int len, input logic [15:0] first,
                           input bit conflict);
        logic [7:0] a;
        send_cmd(1'b0, base, 9'(len));
        chk("ld_cmd_ready_low", cmd_ready, 1'b0);
        for (int i = 0; i < len; i++) begin
            a        = base + 8'(i);
            ld_valid = 1'b1;
            ld_data  = first + 16'(i);
            model_mem[a] = ld_data;
            if (conflict && i == 0) begin
                dm_addr   = 8'd7;
                dm_w_data = 16'hBEEF;
                dm_wr     = 1'b1;
            end
            chk("ld_ready", ld_ready, 1'b1);
            chk("ld_no_early_done", cmd_done, 1'b0);
            tick();
            dm_wr = 1'b0;
        end
        ld_valid = 1'b0;
        chk("ld_done", cmd_done, 1'b1);
        chk("ld_cmd_ready_back", cmd_ready, 1'b1);
        chk("ld_ready_low", ld_ready, 1'b0);
        tick();
        chk("ld_done_pulse", cmd_done, 1'b0);
    endtask

    task automatic do_dump(input logic [7:0] base, input int len, input int stall);
        logic [7:0]  a;
        logic [23:0] e;
        int budget;
        int st;
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            dump_q.push_back({a, model_mem[a]});
        end
        send_cmd(1'b1, base, 9'(len));
        chk("dump_lat_rd", dump_valid, 1'b0);
        tick();
        chk("dump_lat_out", dump_valid, 1'b1);
        budget = 20 * len + 20;
        st     = stall;
        while (dump_q.size() > 0 && budget > 0) begin
            if (dump_valid) begin
                if (st > 0) begin
                    chk("dump_hold_data", dump_data, dump_q[0][15:0]);
                    chk("dump_hold_addr", dump_addr, dump_q[0][23:16]);
                    st--;
                    tick();
                end else begin
                    e = dump_q.pop_front();
                    chk("dump_data", dump_data, e[15:0]);
                    chk("dump_addr", dump_addr, e[23:16]);
                    dump_ready = 1'b1;
                    tick();
                    dump_ready = 1'b0;
                    chk("dump_done", cmd_done, (dump_q.size() == 0) ? 1'b1 : 1'b0);
                end
            end else begin
                tick();
            end
            budget--;
        end
        chk("dump_drained", dump_q.size(), 0);
    endtask

    initial begin
        logic [15:0] exp_same;
        rst = 1'b0;
        dm_addr = '0; dm_rd = 0; dm_wr = 0; dm_w_data = '0;
        cmd_valid = 0; cmd_op = 0; cmd_addr = '0; cmd_len = '0;
        ld_valid = 0; ld_data = '0; dump_ready = 0;
        repeat (2) tick();
        chk("rst_r_data", dm_r_data, 16'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_dump_valid", dump_valid, 1'b0);
        chk("rst_dump_data", dump_data, 16'h0);
        chk("rst_dump_addr", dump_addr, 8'h0);
        chk("rst_cmd_done", cmd_done, 1'b0);
        chk("rst_conflict", proc_conflict, 1'b0);
        rst = 1'b1;
        tick();

        proc_write(8'd7, 16'h7777);
        do_load(8'd254, 4, 16'h0001, 1'b1);
        chk("conflict_set", proc_conflict, 1'b1);
        proc_read(8'd254);
        proc_read(8'd255);
        proc_read(8'd0);
        proc_read(8'd1);
        proc_read(8'd7);

        proc_write(8'd12, 16'h1234);
        proc_read(8'd12);
        tick();
        chk("rd_hold", dm_r_data, 16'h1234);

        proc_write(8'd5, 16'h1111);
`ifdef DM_WRITE_FIRST_EN
        exp_same = 16'h2222;
`else
        exp_same = 16'h1111;
`endif
        dm_addr = 8'd5; dm_w_data = 16'h2222; dm_rd = 1'b1; dm_wr = 1'b1;
        rd_q.push_back(exp_same);
        tick();
        dm_rd = 1'b0; dm_wr = 1'b0;
        chk("same_addr_rd", dm_r_data, rd_q.pop_front());
        model_mem[5] = 16'h2222;
        proc_read(8'd5);

        proc_write(8'd3, 16'h00A0);
        proc_write(8'd4, 16'hFFF6);
        do_dump(8'd3, 2, 3);
        tick();
        do_dump(8'd255, 2, 0);
        tick();

        send_cmd(1'b0, 8'd3, 9'd0);
        chk("len0_done", cmd_done, 1'b1);
        chk("len0_ready", cmd_ready, 1'b1);
        tick();
        chk("len0_pulse", cmd_done, 1'b0);
        proc_read(8'd3);
        chk("conflict_sticky", proc_conflict, 1'b1);

        send_cmd(1'b0, 8'd20, 9'd5);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'h00A1 + 16'(i);
            model_mem[20 + i] = ld_data;
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_ld_ready", ld_ready, 1'b0);
        chk("abort_dump_valid", dump_valid, 1'b0);
        chk("abort_dump_data", dump_data, 16'h0);
        chk("abort_dump_addr", dump_addr, 8'h0);
        chk("abort_cmd_done", cmd_done, 1'b0);
        chk("abort_conflict", proc_conflict, 1'b0);
        chk("abort_r_data", dm_r_data, 16'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_no_done", cmd_done, 1'b0);
        proc_read(8'd20);
        proc_read(8'd21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
